// File: rtl/fp_mul_ctrl_pkg.sv
// fp_mul_ctrl_pkg: shared FPU rounding codes, flag bit indices and controller state encoding.
package fp_mul_ctrl_pkg;
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RZ  = 3'd1;
  localparam logic [2:0] RM_RD  = 3'd2;
  localparam logic [2:0] RM_RU  = 3'd3;
  localparam logic [2:0] RM_RNA = 3'd4;
  localparam logic [31:0] FP_NANQ = 32'h7FC00000;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic logic rm_legal(input logic [2:0] rm);
    return rm <= RM_RNA;
  endfunction
endpackage

// File: rtl/fp_mul_ctrl.sv
// fp_mul_ctrl: issues one multiply to fp_mul, holds operands for its latency, returns the result and sticky flags.
module fp_mul_ctrl
  import fp_mul_ctrl_pkg::*;
#(
  parameter int W   = 32,
  parameter int LAT = 2,
  parameter int CW  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [2:0]   in_rm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic [4:0]   out_flags,
  output logic [4:0]   fflags,
  input  logic         fflags_clr,
  output logic         busy,
  output logic         mul_act,
  output logic [W-1:0] mul_in1,
  output logic [W-1:0] mul_in2,
  output logic [2:0]   mul_rm,
  input  logic [W-1:0] mul_out,
  input  logic         mul_ov,
  input  logic         mul_un,
  input  logic         mul_done,
  input  logic         mul_inv,
  input  logic         mul_inexact
);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0] rm_q, rm_d;
  logic [4:0] flags_q, flags_d, ff_q, ff_d, new_flags;
  logic cap;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    rm_d = rm_q;
    res_d = res_q;
    cap = 1'b0;
    new_flags = '0;
    case (state_q)
      IDLE: if (in_valid) begin
        if (rm_legal(in_rm)) begin
          a_d = in_a;
          b_d = in_b;
          rm_d = in_rm;
          cnt_d = '0;
          state_d = RUN;
        end else begin
          // illegal rounding mode never reaches fp_mul: answer with a quiet NaN and NV
          cap = 1'b1;
          new_flags = 5'b00001 << FLAG_NV;
          res_d = W'(FP_NANQ);
          state_d = DONE;
        end
      end
      RUN: begin
        cnt_d = (cnt_q == CW'(LAT)) ? cnt_q : cnt_q + 1'b1;
        if (cnt_q == CW'(LAT) && mul_done) begin
          cap = 1'b1;
          new_flags = {mul_inv, 1'b0, mul_ov, mul_un, mul_inexact};
          res_d = mul_out;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    flags_d = cap ? new_flags : flags_q;
    ff_d = (fflags_clr ? 5'd0 : ff_q) | new_flags;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      rm_q <= '0;
      res_q <= '0;
      flags_q <= '0;
      ff_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      rm_q <= rm_d;
      res_q <= res_d;
      flags_q <= flags_d;
      ff_q <= ff_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign mul_act = state_q == RUN;
  assign mul_in1 = a_q;
  assign mul_in2 = b_q;
  assign mul_rm = rm_q;
  assign out_res = res_q;
  assign out_flags = flags_q;
  assign fflags = ff_q;
endmodule

// File: tb/tb_fp_mul_ctrl.sv
// tb_fp_mul_ctrl: directed vectors against a cycle-age model of the controller and a stub fp_mul.
module tb_fp_mul_ctrl;
  localparam int W = 32;
  localparam int LAT = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, fflags_clr = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [2:0] in_rm = '0;
  logic in_ready, out_valid, busy, mul_act;
  logic [W-1:0] out_res, mul_in1, mul_in2, mul_out;
  logic [4:0] out_flags, fflags;
  logic [2:0] mul_rm;
  logic mul_ov, mul_un, mul_done, mul_inv, mul_inexact;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  fp_mul_ctrl #(.W(W), .LAT(LAT), .CW(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_rm(in_rm), .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_flags(out_flags), .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy),
    .mul_act(mul_act), .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_rm(mul_rm), .mul_out(mul_out),
    .mul_ov(mul_ov), .mul_un(mul_un), .mul_done(mul_done), .mul_inv(mul_inv), .mul_inexact(mul_inexact)
  );

  // stub fp_mul: result of the current vector appears after LAT+stall active edges
  logic [31:0] cur_res = '0;
  logic [4:0] cur_flags = '0;
  int stall = 0, act_cnt = 0;
  bit act_seen = 0;
  always @(posedge clk or negedge rst) act_cnt <= !rst ? 0 : (mul_act ? act_cnt + 1 : 0);
  assign mul_done = mul_act && act_cnt >= LAT + stall;
  assign mul_out = mul_done ? cur_res : 32'hDEADBEEF;
  assign {mul_inv, mul_ov, mul_un, mul_inexact} = mul_done ? {cur_flags[4], cur_flags[2:0]} : 4'b0;
  always @(negedge clk) if (mul_act) act_seen = 1;

  // model: age counts edges since accept (-1 when no op in flight)
  int age;
  bit m_valid, m_cap;
  logic [31:0] m_res, m_in1, m_in2;
  logic [4:0] m_flags, m_ff, m_nf;
  logic [2:0] m_rm;
  always_comb begin
    m_cap = 1'b0;
    m_nf = '0;
    if (!m_valid && age < 0 && in_valid && in_rm > 3'd4) begin
      m_cap = 1'b1;
      m_nf = 5'b10000;
    end else if (age >= 0 && age + 1 == LAT + 1 + stall) begin
      m_cap = 1'b1;
      m_nf = {cur_flags[4], 1'b0, cur_flags[2:0]};
    end
  end
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      age <= -1; m_valid <= 0; m_res <= '0; m_in1 <= '0; m_in2 <= '0; m_rm <= '0;
      m_flags <= '0; m_ff <= '0;
    end else begin
      if (m_valid) m_valid <= !out_ready;
      else if (m_cap) begin
        m_valid <= 1; age <= -1;
        m_res <= (age < 0) ? 32'h7FC00000 : cur_res;
      end else if (age >= 0) age <= age + 1;
      else if (in_valid) begin
        age <= 0; m_in1 <= in_a; m_in2 <= in_b; m_rm <= in_rm;
      end
      if (m_cap) m_flags <= m_nf;
      m_ff <= (fflags_clr ? 5'd0 : m_ff) | m_nf;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(age < 0 && !m_valid));
    check("busy", 32'(busy), 32'(!(age < 0 && !m_valid)));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("mul_act", 32'(mul_act), 32'(age >= 0));
    check("out_res", out_res, m_res);
    check("out_flags", 32'(out_flags), 32'(m_flags));
    check("fflags", 32'(fflags), 32'(m_ff));
    check("mul_in1", mul_in1, m_in1);
    check("mul_in2", mul_in2, m_in2);
    check("mul_rm", 32'(mul_rm), 32'(m_rm));
  end

  task automatic issue(input logic [31:0] a, b, input logic [2:0] rm, input logic [31:0] r,
                       input logic [4:0] f, input int st, input bit clr_cap, output int lat);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) check("issue_timeout", 32'(in_ready), 32'd1);
    cur_res = r; cur_flags = f; stall = st; act_seen = 0;
    in_a = a; in_b = b; in_rm = rm; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      fflags_clr = clr_cap && (lat == LAT + st);
      @(posedge clk); #1;
      lat++;
    end
    fflags_clr = 0;
    if (!out_valid) check("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic consume(input int hold, input logic [31:0] r);
    for (int i = 0; i < hold; i++) begin
      in_a = 32'h3F800000; in_b = 32'h3F800000; in_rm = 3'd0; in_valid = 1;
      @(posedge clk); #1;
      check("bp_res", out_res, r);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1;
    check("rst_res", out_res, 32'h0);
    check("rst_fflags", 32'(fflags), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1;
    @(posedge clk); #1;
    issue(32'h40000000, 32'h40400000, 3'd0, 32'h40C00000, 5'b00000, 0, 0, lat);
    check("basic_lat", 32'(lat), 32'd3);
    check("basic_res", out_res, 32'h40C00000);
    check("basic_flags", 32'(out_flags), 32'h0);
    consume(0, 32'h40C00000);
    issue(32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 5'b10000, 0, 0, lat);
    check("inv_res", out_res, 32'h7FC00000);
    check("inv_flags", 32'(out_flags), 32'h10);
    check("inv_fflags", 32'(fflags), 32'h10);
    consume(0, 32'h7FC00000);
    issue(32'h3FAAAAAB, 32'h40400000, 3'd0, 32'h40800000, 5'b00001, 0, 0, lat);
    check("nx_res", out_res, 32'h40800000);
    check("nx_flags", 32'(out_flags), 32'h01);
    consume(0, 32'h40800000);
    issue(32'h40000000, 32'h40400000, 3'd0, 32'h40C00000, 5'b00000, 0, 1, lat);
    check("clr_exact_fflags", 32'(fflags), 32'h00);
    consume(0, 32'h40C00000);
    issue(32'h3FAAAAAB, 32'h40400000, 3'd0, 32'h40800000, 5'b00001, 0, 1, lat);
    check("clr_nx_fflags", 32'(fflags), 32'h01);
    consume(0, 32'h40800000);
    issue(32'h40000000, 32'h40400000, 3'd1, 32'h40C00000, 5'b00000, 0, 0, lat);
    consume(5, 32'h40C00000);
    issue(32'h40000000, 32'h40400000, 3'd7, 32'h12345678, 5'b00000, 0, 0, lat);
    check("ill_lat", 32'(lat), 32'd0);
    check("ill_res", out_res, 32'h7FC00000);
    check("ill_act", 32'(act_seen), 32'd0);
    check("ill_fflags", 32'(fflags), 32'h11);
    consume(0, 32'h7FC00000);
    issue(32'h40000000, 32'h40400000, 3'd4, 32'h40C00000, 5'b00000, 2, 0, lat);
    check("stall_lat", 32'(lat), 32'd5);
    consume(1, 32'h40C00000);
    in_a = 32'h40000000; in_b = 32'h40400000; in_rm = 3'd0; in_valid = 1;
    cur_res = 32'h40C00000; cur_flags = 5'b00000; stall = 0;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #2;
    rst = 0;
    #1;
    check("mid_rst_res", out_res, 32'h0);
    check("mid_rst_flags", 32'(out_flags), 32'h0);
    check("mid_rst_fflags", 32'(fflags), 32'h0);
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_act", 32'(mul_act), 32'h0);
    check("mid_rst_in1", mul_in1, 32'h0);
    @(posedge clk); #1;
    rst = 1;
    issue(32'h40000000, 32'h40400000, 3'd0, 32'h40C00000, 5'b00000, 0, 0, lat);
    check("post_rst_lat", 32'(lat), 32'd3);
    check("post_rst_res", out_res, 32'h40C00000);
    check("post_rst_fflags", 32'(fflags), 32'h0);
    consume(0, 32'h40C00000);
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
